// File: rtl/booth_simd_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module   : booth_simd_datapath_if
//  Purpose  : Control-strobe / result bundle between the Booth control FSM
//             and the SIMD Booth datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface booth_simd_datapath_if #(
    parameter int W = 16
);
    logic             mode;
    logic [W-1:0]     mcand_in;
    logic [W-1:0]     mplier_in;
    logic             clr;
    logic             clr_count;
    logic             ld;
    logic             dec;
    logic             done;
    logic             eqz;
    logic [2*W-1:0]   product;
    logic             product_valid;

    modport master (
        output mode, mcand_in, mplier_in, clr, clr_count, ld, dec, done,
        input  eqz, product, product_valid
    );

    modport slave (
        input  mode, mcand_in, mplier_in, clr, clr_count, ld, dec, done,
        output eqz, product, product_valid
    );
endinterface
`default_nettype wire

// File: rtl/booth_simd_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : booth_simd_datapath
//  Purpose  : Radix-2 signed Booth datapath; one WxW product or two
//             independent (W/2)x(W/2) lane products.
//  Revision : 1.0  initial release
// ============================================================================
module booth_simd_datapath #(
    parameter int W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    booth_simd_datapath_if.slave   bus
);
    localparam int N  = W / 2;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] c_cnt_full = CW'(W);
    localparam logic [CW-1:0] c_cnt_lane = CW'(N);

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_q;
    logic [W-1:0]     r_m;
    logic [1:0]       r_qm1;
    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic [2*W-1:0]   r_product;
    logic             r_valid;

    logic [W:0]       w_sum_f;
    logic [N:0]       w_sum_l0;
    logic [N:0]       w_sum_l1;
    logic [W-1:0]     w_a_nx;
    logic [W-1:0]     w_q_nx;
    logic [1:0]       w_qm1_nx;
    logic             w_mode_eff;

    // Full-width and per-lane partial sums, each one bit wider than its
    // operands so the most negative multiplicand cannot overflow.
    always_comb begin
        w_sum_f  = {r_a[W-1], r_a};
        w_sum_l0 = {r_a[N-1], r_a[N-1:0]};
        w_sum_l1 = {r_a[W-1], r_a[W-1:N]};

        unique case ({r_q[0], r_qm1[0]})
            2'b01: begin
                w_sum_f  = {r_a[W-1], r_a} + {r_m[W-1], r_m};
                w_sum_l0 = {r_a[N-1], r_a[N-1:0]} + {r_m[N-1], r_m[N-1:0]};
            end
            2'b10: begin
                w_sum_f  = {r_a[W-1], r_a} - {r_m[W-1], r_m};
                w_sum_l0 = {r_a[N-1], r_a[N-1:0]} - {r_m[N-1], r_m[N-1:0]};
            end
            default: ;
        endcase

        unique case ({r_q[N], r_qm1[1]})
            2'b01:   w_sum_l1 = {r_a[W-1], r_a[W-1:N]} + {r_m[W-1], r_m[W-1:N]};
            2'b10:   w_sum_l1 = {r_a[W-1], r_a[W-1:N]} - {r_m[W-1], r_m[W-1:N]};
            default: ;
        endcase
    end

    always_comb begin
        if (!r_mode) begin
            w_a_nx   = w_sum_f[W:1];
            w_q_nx   = {w_sum_f[0], r_q[W-1:1]};
            w_qm1_nx = {r_qm1[1], r_q[0]};
        end else begin
            w_a_nx   = {w_sum_l1[N:1], w_sum_l0[N:1]};
            w_q_nx   = {w_sum_l1[0], r_q[W-1:N+1], w_sum_l0[0], r_q[N-1:1]};
            w_qm1_nx = {r_q[N], r_q[0]};
        end
    end

    // A counter load coinciding with clr must see the mode being latched.
    assign w_mode_eff = bus.clr ? bus.mode : r_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_q    <= '0;
            r_m    <= '0;
            r_qm1  <= '0;
            r_mode <= 1'b0;
        end else if (bus.clr) begin
            r_a    <= '0;
            r_q    <= bus.mplier_in;
            r_m    <= bus.mcand_in;
            r_qm1  <= '0;
            r_mode <= bus.mode;
        end else if (bus.ld && (r_cnt != '0)) begin
            r_a    <= w_a_nx;
            r_q    <= w_q_nx;
            r_qm1  <= w_qm1_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.clr_count) begin
            r_cnt <= w_mode_eff ? c_cnt_lane : c_cnt_full;
        end else if (bus.dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_product <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= bus.done;
            if (bus.done) begin
                if (!r_mode)
                    r_product <= {r_a, r_q};
                else
                    r_product <= {r_a[W-1:N], r_q[W-1:N], r_a[N-1:0], r_q[N-1:0]};
            end
        end
    end

    assign bus.eqz           = (r_cnt == '0);
    assign bus.product       = r_product;
    assign bus.product_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_booth_simd_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_simd_datapath
//  Purpose  : Directed self-checking bench for booth_simd_datapath (W=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_simd_datapath;
    localparam int W = 16;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    booth_simd_datapath_if #(.W(W)) bus ();

    booth_simd_datapath #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2*W-1:0] obs,
                         input logic [2*W-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_strobes();
        bus.clr       = 1'b0;
        bus.clr_count = 1'b0;
        bus.ld        = 1'b0;
        bus.dec       = 1'b0;
        bus.done      = 1'b0;
    endtask

    // Start, hold ld/dec for 'total' cycles, capture, then check the result
    // and the one-cycle valid pulse. Operand inputs are scrambled after clr.
    task automatic run(input string tag, input logic m, input logic [W-1:0] mc,
                       input logic [W-1:0] mp, input int nsteps, input int total,
                       input logic simul, input logic [2*W-1:0] exp);
        bus.mode      = m;
        bus.mcand_in  = mc;
        bus.mplier_in = mp;
        bus.clr       = 1'b1;
        bus.clr_count = 1'b1;
        bus.ld        = simul;
        bus.dec       = simul;
        tick();
        bus.clr       = 1'b0;
        bus.clr_count = 1'b0;
        bus.mode      = ~m;
        bus.mcand_in  = ~mc;
        bus.mplier_in = mp ^ 16'h5A5A;
        check({tag, "_eqz_start"}, {31'd0, bus.eqz}, 32'd0);
        bus.ld  = 1'b1;
        bus.dec = 1'b1;
        for (int i = 0; i < total; i++) begin
            tick();
            if (i == nsteps - 2)
                check({tag, "_eqz_before_last"}, {31'd0, bus.eqz}, 32'd0);
            if (i >= nsteps - 1 && (i == nsteps - 1 || i == total - 1))
                check({tag, "_eqz_after_last"}, {31'd0, bus.eqz}, 32'd1);
        end
        bus.ld   = 1'b0;
        bus.dec  = 1'b0;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check({tag, "_product"}, bus.product, exp);
        check({tag, "_valid_pulse"}, {31'd0, bus.product_valid}, 32'd1);
        tick();
        check({tag, "_valid_drop"}, {31'd0, bus.product_valid}, 32'd0);
        check({tag, "_product_hold"}, bus.product, exp);
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.mode      = 1'b0;
        bus.mcand_in  = '0;
        bus.mplier_in = '0;
        idle_strobes();
        tick();
        tick();
        rst = 1'b0;

        check("reset_eqz", {31'd0, bus.eqz}, 32'd1);
        check("reset_product", bus.product, 32'd0);
        check("reset_valid", {31'd0, bus.product_valid}, 32'd0);

        run("m0_3x-5", 1'b0, 16'h0003, 16'hFFFB, 16, 16, 1'b0, 32'hFFFFFFF1);
        run("m0_min_x_min", 1'b0, 16'h8000, 16'h8000, 16, 16, 1'b0, 32'h40000000);
        run("m1_lanes", 1'b1, 16'h7F80, 16'h0280, 8, 8, 1'b0, 32'h00FE4000);
        run("m1_neg_lanes", 1'b1, 16'hFD05, 16'h07FA, 8, 8, 1'b0, 32'hFFEBFFE2);
        run("m0_trailing", 1'b0, 16'h0003, 16'hFFFB, 16, 20, 1'b0, 32'hFFFFFFF1);
        run("m1_trailing", 1'b1, 16'h7F80, 16'h0280, 8, 12, 1'b0, 32'h00FE4000);
        run("m0_simul", 1'b0, 16'h0007, 16'h0009, 16, 16, 1'b1, 32'h0000003F);

        // Abort after five steps; everything observable must return to reset.
        bus.mode      = 1'b0;
        bus.mcand_in  = 16'h1234;
        bus.mplier_in = 16'h0F0F;
        bus.clr       = 1'b1;
        bus.clr_count = 1'b1;
        tick();
        bus.clr       = 1'b0;
        bus.clr_count = 1'b0;
        bus.ld        = 1'b1;
        bus.dec       = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst  = 1'b1;
        bus.done = 1'b1;
        tick();
        rst = 1'b0;
        idle_strobes();
        check("rst_mid_eqz", {31'd0, bus.eqz}, 32'd1);
        check("rst_mid_product", bus.product, 32'd0);
        check("rst_mid_valid", {31'd0, bus.product_valid}, 32'd0);
        tick();
        check("rst_mid_valid_after", {31'd0, bus.product_valid}, 32'd0);

        run("post_rst_3x-5", 1'b0, 16'h0003, 16'hFFFB, 16, 17, 1'b0, 32'hFFFFFFF1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
